alu_seq: RTL and testbench

//   Sequential, parametrised successor to the combinational alu. Operands and op are

---
 rtl/alu_seq.sv | 162 ++++++++++++++++
 tb/tb_alu_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: captures op/operands on start, runs single-cycle ops in one edge and an
// unsigned shift-add multiply over W edges; result/flag are held until the next done.
module alu_seq #(
  parameter int DATA_BUS_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [3:0]                op,
  input  logic [DATA_BUS_WIDTH-1:0] register1,
  input  logic [DATA_BUS_WIDTH-1:0] register2,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_BUS_WIDTH-1:0] result,
  output logic [3:0]                flag
);

  localparam int W  = DATA_BUS_WIDTH;
  localparam int SW = $clog2(W);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

  state_t state, state_nx;

  logic [3:0]      op_q;
  logic [W-1:0]    a_q, b_q;
  logic [SW-1:0]   cnt;
  logic [2*W-1:0]  acc, acc_nx, pp;
  logic [W:0]      sum, diff, shl_full, shr_full;
  logic [SW-1:0]   sh;
  logic [W-1:0]    exec_res;
  logic [3:0]      exec_flag;
  logic            accept, mul_last;

  // {V,N,C,Z} from a computed value plus its overflow and carry/borrow bits
  function automatic logic [3:0] pack_flag(input logic v, input logic c, input logic [W-1:0] val);
    return {v, val[W-1], c, ~|val};
  endfunction

  function automatic logic add_ovf(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                                   input logic signed [W-1:0] s);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                                   input logic signed [W-1:0] d);
    return (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
  endfunction

  assign busy     = (state != S_IDLE);
  assign accept   = start && (state == S_IDLE);
  assign mul_last = (state == S_MUL) && (cnt == SW'(W-1));

  assign sh       = b_q[SW-1:0];
  assign sum      = {1'b0, a_q} + {1'b0, b_q};
  assign diff     = {1'b0, a_q} - {1'b0, b_q};
  // The extra bit on each shift catches the last bit shifted out; it is 0 for a zero shift.
  assign shl_full = {1'b0, a_q} << sh;
  assign shr_full = {a_q, 1'b0} >> sh;

  assign pp     = b_q[cnt] ? ({{W{1'b0}}, a_q} << cnt) : '0;
  assign acc_nx = acc + pp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = (op == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC: state_nx = S_IDLE;
      S_MUL:  if (mul_last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    exec_res  = result;
    exec_flag = flag;
    case (op_q)
      OP_ADD: begin
        exec_res  = sum[W-1:0];
        exec_flag = pack_flag(add_ovf(a_q, b_q, sum[W-1:0]), sum[W], sum[W-1:0]);
      end
      OP_SUB: begin
        exec_res  = diff[W-1:0];
        exec_flag = pack_flag(sub_ovf(a_q, b_q, diff[W-1:0]), diff[W], diff[W-1:0]);
      end
      OP_CMP:
        exec_flag = pack_flag(sub_ovf(a_q, b_q, diff[W-1:0]), diff[W], diff[W-1:0]);
      OP_AND: begin
        exec_res  = a_q & b_q;
        exec_flag = pack_flag(1'b0, 1'b0, a_q & b_q);
      end
      OP_OR: begin
        exec_res  = a_q | b_q;
        exec_flag = pack_flag(1'b0, 1'b0, a_q | b_q);
      end
      OP_XOR: begin
        exec_res  = a_q ^ b_q;
        exec_flag = pack_flag(1'b0, 1'b0, a_q ^ b_q);
      end
      OP_SHL: begin
        exec_res  = shl_full[W-1:0];
        exec_flag = pack_flag(1'b0, shl_full[W], shl_full[W-1:0]);
      end
      OP_SHR: begin
        exec_res  = shr_full[W:1];
        exec_flag = pack_flag(1'b0, shr_full[0], shr_full[W:1]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      acc    <= '0;
      done   <= 1'b0;
      result <= '0;
      flag   <= '0;
    end else begin
      done <= (state == S_EXEC) || mul_last;
      if (accept) begin
        op_q <= op;
        a_q  <= register1;
        b_q  <= register2;
        cnt  <= '0;
        acc  <= '0;
      end
      if (state == S_EXEC) begin
        result <= exec_res;
        flag   <= exec_flag;
      end
      // One partial product per edge, LSB of B first; only the final sum reaches result.
      if (state == S_MUL) begin
        acc <= acc_nx;
        cnt <= cnt + SW'(1);
        if (mul_last) begin
          result <= acc_nx[W-1:0];
          flag   <= pack_flag(1'b0, |acc_nx[2*W-1:W], acc_nx[W-1:0]);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed corner cases plus random ops compared against an
// integer-arithmetic reference model of the ALU rules.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] register1, register2;
  logic         busy, done;
  logic [W-1:0] result;
  logic [3:0]   flag;

  int checks = 0;
  int errors = 0;
  int exp_res = 0, exp_flag = 0, exp_lat = 1;

  always #5 clk = ~clk;

  alu_seq #(.DATA_BUS_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .register1(register1), .register2(register2),
    .busy(busy), .done(done), .result(result), .flag(flag)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sx(int v);
    return (v >= (1 << (W-1))) ? v - (1 << W) : v;
  endfunction

  // Reference: plain integer arithmetic, updates expected result/flag/latency
  task automatic model(input int o, input int a, input int b);
    int mask, smax, smin, val, c, v, sh, s;
    bit wr_res, wr_flag;
    mask = (1 << W) - 1; smax = (1 << (W-1)) - 1; smin = -(1 << (W-1));
    sh = b % W; c = 0; v = 0; val = 0; wr_res = 1; wr_flag = 1;
    exp_lat = (o == 7) ? W : 1;
    case (o)
      0: begin val = a + b; c = (val > mask); s = sx(a) + sx(b); v = (s > smax) || (s < smin); end
      1, 8: begin val = a - b; c = (a < b); s = sx(a) - sx(b); v = (s > smax) || (s < smin); end
      2: val = a & b;
      3: val = a | b;
      4: val = a ^ b;
      5: begin val = a << sh; c = (sh != 0) ? ((a >> (W - sh)) & 1) : 0; end
      6: begin val = a >> sh; c = (sh != 0) ? ((a >> (sh - 1)) & 1) : 0; end
      7: begin val = a * b; c = ((val >> W) != 0); end
      default: begin wr_res = 0; wr_flag = 0; end
    endcase
    if (o == 8) wr_res = 0;
    val = val & mask;
    if (wr_res) exp_res = val;
    if (wr_flag) exp_flag = v * 8 + ((val >> (W-1)) & 1) * 4 + c * 2 + ((val == 0) ? 1 : 0);
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int lat;
    bit seen;
    model(int'(o), int'(a), int'(b));
    @(negedge clk);
    check({tag, "_idle"}, busy, 0);
    start = 1'b1; op = o; register1 = a; register2 = b;
    @(posedge clk); #1;
    start = 1'b0; op = 4'($urandom); register1 = W'($urandom); register2 = W'($urandom);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_done_lo"}, done, 0);
    seen = 0; lat = 0;
    for (int n = 1; n <= W + 4 && !seen; n++) begin
      @(posedge clk); #1;
      if (done) begin seen = 1; lat = n; end
    end
    if (!seen) check({tag, "_timeout"}, 0, 1);
    else begin
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_busy_done"}, busy, 0);
      check({tag, "_res"}, result, exp_res);
      check({tag, "_flag"}, flag, exp_flag);
    end
  endtask

  initial begin
    int dones, lat;
    logic [W-1:0] a, b;
    rst_n = 1'b0; start = 1'b0; op = '0; register1 = '0; register2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res", result, 0);
    check("rst_flag", flag, 0);
    @(negedge clk); rst_n = 1'b1;

    run_op("add_ff_01", 4'd0, 8'hFF, 8'h01);
    run_op("sub_80_01", 4'd1, 8'h80, 8'h01);
    run_op("cmp_05_07", 4'd8, 8'h05, 8'h07);
    run_op("mul_0f_11", 4'd7, 8'h0F, 8'h11);
    run_op("mul_10_10", 4'd7, 8'h10, 8'h10);
    run_op("shl_81_1", 4'd5, 8'h81, 8'h01);
    run_op("shr_81_0", 4'd6, 8'h81, 8'h00);
    run_op("nop_12", 4'd12, 8'h33, 8'h44);

    // start during MUL must be ignored
    model(7, 8'h0F, 8'h11);
    @(negedge clk);
    start = 1'b1; op = 4'd7; register1 = 8'h0F; register2 = 8'h11;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; lat = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      start = (n == 2); op = 4'd0; register1 = 8'h01; register2 = 8'h01;
      @(posedge clk); #1;
      if (done) begin dones++; lat = n; end
    end
    start = 1'b0;
    check("ign_dones", dones, 1);
    check("ign_lat", lat, W);
    check("ign_res", result, exp_res);
    check("ign_flag", flag, exp_flag);

    // reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1; op = 4'd7; register1 = 8'hAB; register2 = 8'hCD;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_res", result, 0);
    check("abort_flag", flag, 0);
    exp_res = 0; exp_flag = 0;
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_nodone", dones, 0);
    run_op("add_after_rst", 4'd0, 8'h01, 8'h02);
    check("add_after_rst_3", result, 8'h03);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: a = 8'h00; 1: a = 8'hFF; 2: a = 8'h80; 3: a = 8'h7F; default: a = W'($urandom);
      endcase
      b = ($urandom_range(0, 3) == 0) ? 8'h80 : W'($urandom);
      run_op("rand", 4'($urandom_range(0, 15)), a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
